// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: latches a parallel word and drives start, data (LSB first),
// optional parity and stop bits onto a registered, idle-high line.
module uart_tx_frame_serializer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH);

  localparam logic [CntW-1:0] LastClk  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                r_state,   w_state_nxt;
  logic [CntW-1:0]       r_clk_cnt, w_clk_cnt_nxt;
  logic [BitW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
  logic                  r_par_en,  w_par_en_nxt;
  logic                  r_par_bit, w_par_bit_nxt;
  logic                  r_tx,      w_tx_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  r_done,    w_done_nxt;
  logic                  w_bit_end;

  assign w_bit_end = (r_clk_cnt == LastClk);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if (r_state != StIdle) begin
      w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + CntW'(1);
    end

    unique case (r_state)
      StIdle: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_nxt   = StData;
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LastData) begin
            w_bit_cnt_nxt = '0;
            if (r_par_en) begin
              w_state_nxt = StParity;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = StStop;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + BitW'(1);
          end
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_state_nxt   = StStop;
          w_tx_nxt      = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LastStop) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BitW'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Accept in idle, or on the final stop edge so back-to-back frames have no gap.
    if (DATA_VALID && (r_state == StIdle ||
        (r_state == StStop && w_bit_end && r_bit_cnt == LastStop))) begin
      w_state_nxt   = StStart;
      w_clk_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = P_DATA;
      w_par_en_nxt  = PAR_EN;
      w_par_bit_nxt = (^P_DATA) ^ PAR_TYP;
      w_tx_nxt      = 1'b0;
      w_busy_nxt    = 1'b1;
    end
  end

  assign TX_OUT     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: scoreboard of expected frames checked bit-by-bit
// every cycle on two instances (one and two stop bits).
module tb_uart_tx_frame_serializer;

  localparam int Cpb = 4;

  typedef struct {
    logic [12:0] bits;
    int          len;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       exp_par;
  } vec_t;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_EN, PAR_TYP;
  logic       tx1, busy1, done1, tx2, busy2, done2;
  logic       sel;
  logic       s_tx, s_busy, s_done;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t sb_q[$];
  frame_t rec;
  logic   active      = 1'b0;
  logic   end_pending = 1'b0;
  int     bit_cyc     = 0;
  int     cyc_cnt     = 0;
  int     last_done   = -1;
  int     done_gap    = 0;
  int     n_done      = 0;
  int     n_busy_low  = 0;

  always #5 clk = ~clk;

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .STOP_BITS(1)) u_dut1 (
    .CLK(clk), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .TX_OUT(tx1), .busy(busy1), .frame_done(done1)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .STOP_BITS(2)) u_dut2 (
    .CLK(clk), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .TX_OUT(tx2), .busy(busy2), .frame_done(done2)
  );

  assign s_tx   = sel ? tx2   : tx1;
  assign s_busy = sel ? busy2 : busy1;
  assign s_done = sel ? done2 : done1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d, input logic pe, input logic par,
                                input int stops);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    if (pe) f.bits[9] = par;
    f.len = 1 + 8 + (pe ? 1 : 0) + stops;
    return f;
  endfunction

  // Monitor: DUT outputs settle after posedge; inputs only change at negedge+1.
  always @(negedge clk) begin
    cyc_cnt++;
    if (RST) begin
      check("reset_tx", s_tx, 1);
      check("reset_busy", s_busy, 0);
      check("reset_done", s_done, 0);
      active      = 1'b0;
      end_pending = 1'b0;
      sb_q.delete();
    end else begin
      check("frame_done", s_done, end_pending);
      if (end_pending) begin
        if (last_done >= 0) done_gap = cyc_cnt - last_done;
        last_done = cyc_cnt;
        n_done++;
      end
      end_pending = 1'b0;
      if (!active && s_busy && sb_q.size() != 0) begin
        rec     = sb_q.pop_front();
        active  = 1'b1;
        bit_cyc = 0;
      end
      if (active) begin
        check("tx_bit", s_tx, rec.bits[bit_cyc / Cpb]);
        check("busy_in_frame", s_busy, 1);
        bit_cyc++;
        if (bit_cyc == rec.len * Cpb) begin
          active      = 1'b0;
          end_pending = 1'b1;
        end
      end else begin
        n_busy_low++;
        check("idle_tx", s_tx, 1);
        check("idle_busy", s_busy, 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge clk); #1;
    DATA_VALID = 1'b0;
    P_DATA  = 8'($urandom);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge clk); #2;
      k++;
    end while ((active || end_pending || sb_q.size() != 0) && k < budget);
    check("wait_timeout", (k < budget) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input logic sel_v);
    @(negedge clk); #1;
    RST = 1'b1; sel = sel_v; DATA_VALID = 1'b0;
    @(negedge clk); #1;
    RST = 1'b0;
  endtask

  vec_t vecs[8];
  int   d0, low0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h55, 1'b0, 1'b0, 1'b0};

    // Reset held with DATA_VALID high; first accept on the edge after release.
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    RST = 1'b0;
    sb_q.push_back(mk(8'hA5, 1'b0, 1'b0, 1));
    @(negedge clk); #1;
    DATA_VALID = 1'b0;
    P_DATA = 8'h3F;
    wait_idle(100);
    check("reset_accept_frames", n_done, 1);

    for (int i = 0; i < 8; i++) begin
      d0 = n_done;
      sb_q.push_back(mk(vecs[i].data, vecs[i].pe, vecs[i].exp_par, 1));
      send(vecs[i].data, vecs[i].pe, vecs[i].pt);
      wait_idle(100);
      check("vec_frame_count", n_done - d0, 1);
    end

    // Back-to-back, two stop bits, parity on: 48-cycle frames with no idle gap.
    do_reset(1'b1);
    d0 = n_done;
    PAR_EN = 1'b1; PAR_TYP = 1'b0; P_DATA = 8'h3C; DATA_VALID = 1'b1;
    sb_q.push_back(mk(8'h3C, 1'b1, 1'b0, 2));
    sb_q.push_back(mk(8'hC3, 1'b1, 1'b0, 2));
    low0 = n_busy_low;
    @(negedge clk); #1;
    P_DATA = 8'hC3;
    repeat (48) @(negedge clk);
    #1;
    DATA_VALID = 1'b0;
    check("b2b_busy_gap", n_busy_low - low0, 0);
    wait_idle(150);
    check("b2b_frame_count", n_done - d0, 2);
    check("b2b_done_spacing", done_gap, 48);

    // DATA_VALID mid-frame is ignored; no extra frame follows.
    do_reset(1'b0);
    d0 = n_done;
    sb_q.push_back(mk(8'h00, 1'b0, 1'b0, 1));
    send(8'h00, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #1;
    P_DATA = 8'hFF; DATA_VALID = 1'b1;
    @(negedge clk); #1;
    DATA_VALID = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    check("ignore_frame_count", n_done - d0, 1);

    // Reset during data bit 3 abandons the frame; the next frame is clean.
    d0 = n_done;
    sb_q.push_back(mk(8'hA5, 1'b0, 1'b0, 1));
    send(8'hA5, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    #1;
    RST = 1'b1;
    @(negedge clk); #1;
    check("midrst_tx", s_tx, 1);
    check("midrst_busy", s_busy, 0);
    RST = 1'b0;
    sb_q.push_back(mk(8'h55, 1'b0, 1'b0, 1));
    send(8'h55, 1'b0, 1'b0);
    wait_idle(100);
    check("midrst_frame_count", n_done - d0, 1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
